// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory-access stage: operation codes, exception codes,
// bus/writeback payloads and decode helpers. Data and address widths are fixed at 32.
package mips_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned EXC_W  = 5;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [OP_W-1:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_BUS_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

    typedef struct packed {
        logic              valid;
        logic              reg_we;
        logic [REG_W-1:0]  reg_waddr;
        logic [DATA_W-1:0] reg_wdata;
        logic              exc;
        logic [EXC_W-1:0]  exc_code;
        logic [ADDR_W-1:0] badvaddr;
    } wb_bundle_t;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
               (op == MEM_LHU) || (op == MEM_LW);
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_misaligned(input logic [OP_W-1:0] op, input logic [1:0] lo);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return lo[0];
            MEM_LW, MEM_SW:          return lo != 2'b00;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [BE_W-1:0] byte_enables(input logic [OP_W-1:0] op, input logic [1:0] lo);
        case (op)
            MEM_SB:  return BE_W'(4'b0001 << lo);
            MEM_SH:  return BE_W'(4'b0011 << lo);
            default: return 4'b1111;
        endcase
    endfunction

    // Sub-word stores are replicated across lanes; byte enables pick the live lane.
    function automatic logic [DATA_W-1:0] store_lanes(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] wdata);
        case (op)
            MEM_SB:  return {4{wdata[7:0]}};
            MEM_SH:  return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Little-endian lane select plus sign/zero extension of a 32-bit read word.
module load_align
    import mips_mem_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addr_lo,
    input  logic [OP_W-1:0]   mem_op,
    output logic [DATA_W-1:0] result_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    assign byte_c = rdata[{addr_lo, 3'b000} +: 8];
    assign half_c = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result_c = rdata;
        case (mem_op)
            MEM_LB:  result_c = {{24{byte_c[7]}}, byte_c};
            MEM_LBU: result_c = {24'd0, byte_c};
            MEM_LH:  result_c = {{16{half_c[15]}}, half_c};
            MEM_LHU: result_c = {16'd0, half_c};
            default: result_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MIPS memory-access stage: issues one bus transaction per load/store, flags address
// errors, aligns load data and hands a registered result bundle to writeback.
module mem_access
    import mips_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [OP_W-1:0]   ex_mem_op,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_reg_we,
    input  logic [REG_W-1:0]  ex_reg_waddr,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [BE_W-1:0]   bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              wb_valid,
    output logic              wb_reg_we,
    output logic [REG_W-1:0]  wb_reg_waddr,
    output logic [DATA_W-1:0] wb_reg_wdata,
    output logic              wb_exc,
    output logic [EXC_W-1:0]  wb_exc_code,
    output logic [ADDR_W-1:0] wb_badvaddr
);

    state_e            state_q, state_d;
    bus_cmd_t          bus_q, bus_d;
    wb_bundle_t        wb_q, wb_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic              reg_we_q, reg_we_d;
    logic [REG_W-1:0]  reg_waddr_q, reg_waddr_d;
    logic [DATA_W-1:0] load_data_c;

    load_align u_load_align (
        .rdata    (bus_rdata),
        .addr_lo  (addr_lo_q),
        .mem_op   (op_q),
        .result_c (load_data_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bus_q       <= '0;
            wb_q        <= '0;
            op_q        <= '0;
            addr_lo_q   <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            wb_q        <= wb_d;
            op_q        <= op_d;
            addr_lo_q   <= addr_lo_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
        end
    end

    // Next-state, bus command and writeback bundle; wb fields hold except for the valid pulse.
    always_comb begin
        state_d     = state_q;
        bus_d       = bus_q;
        wb_d        = wb_q;
        wb_d.valid  = 1'b0;
        op_d        = op_q;
        addr_lo_d   = addr_lo_q;
        reg_we_d    = reg_we_q;
        reg_waddr_d = reg_waddr_q;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    op_d        = ex_mem_op;
                    addr_lo_d   = ex_addr[1:0];
                    reg_we_d    = ex_reg_we;
                    reg_waddr_d = ex_reg_waddr;
                    if (!is_load(ex_mem_op) && !is_store(ex_mem_op)) begin
                        wb_d = '{valid: 1'b1, reg_we: ex_reg_we, reg_waddr: ex_reg_waddr,
                                 reg_wdata: ex_result, exc: 1'b0, exc_code: '0, badvaddr: '0};
                    end else if (is_misaligned(ex_mem_op, ex_addr[1:0])) begin
                        wb_d = '{valid: 1'b1, reg_we: 1'b0, reg_waddr: ex_reg_waddr,
                                 reg_wdata: '0, exc: 1'b1,
                                 exc_code: is_load(ex_mem_op) ? EXC_ADEL : EXC_ADES,
                                 badvaddr: ex_addr};
                    end else begin
                        state_d = ST_BUS_WAIT;
                        bus_d   = '{req: 1'b1, we: is_store(ex_mem_op),
                                    addr: {ex_addr[ADDR_W-1:2], 2'b00},
                                    be: byte_enables(ex_mem_op, ex_addr[1:0]),
                                    wdata: store_lanes(ex_mem_op, ex_wdata)};
                    end
                end
            end
            ST_BUS_WAIT: begin
                if (bus_q.req && bus_ack) begin
                    state_d   = ST_IDLE;
                    bus_d.req = 1'b0;
                    wb_d = '{valid: 1'b1, reg_we: is_load(op_q) && reg_we_q,
                             reg_waddr: reg_waddr_q,
                             reg_wdata: is_load(op_q) ? load_data_c : '0,
                             exc: 1'b0, exc_code: '0, badvaddr: '0};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ex_ready     = (state_q == ST_IDLE);
    assign bus_req      = bus_q.req;
    assign bus_we       = bus_q.we;
    assign bus_addr     = bus_q.addr;
    assign bus_be       = bus_q.be;
    assign bus_wdata    = bus_q.wdata;
    assign wb_valid     = wb_q.valid;
    assign wb_reg_we    = wb_q.reg_we;
    assign wb_reg_waddr = wb_q.reg_waddr;
    assign wb_reg_wdata = wb_q.reg_wdata;
    assign wb_exc       = wb_q.exc;
    assign wb_exc_code  = wb_q.exc_code;
    assign wb_badvaddr  = wb_q.badvaddr;

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access pipeline stage of the MIPS CPU, directly upstream of the writeback stage.
- Accepts one instruction at a time from execute and performs LB/LBU/LH/LHU/LW/SB/SH/SW over a request/acknowledge data bus.
- Aligns and extends load data, detects address-error exceptions, and delivers a registered result bundle to writeback.
- Stalls execute while a bus transaction is outstanding.

Parameters:
- DATA_W, 32, data bus and register width (fixed at 32 in this design).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock, all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- ex_valid  in  1  execute presents an instruction.
- ex_ready  out  1  stage can accept; equals (state==IDLE).
- ex_mem_op  in  4  memory operation code (package enum).
- ex_addr  in  ADDR_W  effective byte address.
- ex_wdata  in  DATA_W  store data (rt).
- ex_result  in  DATA_W  ALU result for non-memory ops.
- ex_reg_we  in  1  instruction writes a GPR.
- ex_reg_waddr  in  5  destination GPR.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = store.
- bus_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00}).
- bus_be  out  4  byte enables.
- bus_wdata  out  DATA_W  lane-replicated store data.
- bus_ack  in  1  transaction complete; bus_rdata valid this cycle.
- bus_rdata  in  DATA_W  read data.
- wb_valid  out  1  one-cycle pulse per retired instruction.
- wb_reg_we  out  1  write enable to the register file.
- wb_reg_waddr  out  5  destination GPR.
- wb_reg_wdata  out  DATA_W  value to write.
- wb_exc  out  1  address-error exception.
- wb_exc_code  out  5  4 = AdEL, 5 = AdES.
- wb_badvaddr  out  ADDR_W  faulting address.

Behaviour:
- Reset (async, rst=1): state=IDLE. bus_req, bus_we, bus_be, bus_addr, bus_wdata are 0. All wb_* outputs are 0. Any in-flight transaction is abandoned. The bus must tolerate request withdrawal.
- FSM has two states, IDLE and BUS_WAIT.
- Acceptance happens on a rising edge with ex_valid & ex_ready. All operand fields are latched at that edge.
- Non-memory op (MEM_NONE): next cycle wb_valid=1, wb_reg_we=ex_reg_we, wb_reg_wdata=ex_result. Stays in IDLE. Throughput is 1 per cycle.
- Misalignment checks: LH/LHU/SH fault when addr[0]!=0; LW/SW fault when addr[1:0]!=0.
- On a misaligned access: no bus request is issued. Next cycle wb_valid=1, wb_exc=1, wb_exc_code=4 for loads or 5 for stores, wb_badvaddr=addr, wb_reg_we=0. Stays in IDLE.
- Aligned memory op: go to BUS_WAIT. Registered bus_req=1 from the following cycle. bus_addr, bus_be, bus_we, bus_wdata stay constant until ack.
- Byte enables: SB uses 4'b0001<<addr[1:0]. SH uses 4'b0011<<addr[1:0]. SW and all loads use 4'b1111.
- Store data lanes: SB replicates the byte to all 4 lanes. SH replicates the half to both halves. SW passes the word through.
- bus_ack is sampled only when bus_req=1 in BUS_WAIT.
- At the ack edge: bus_req→0, state→IDLE, wb_valid=1 next cycle.
- Load data is selected from bus_rdata little-endian by addr[1:0]:
  - LB and LH are sign-extended; LBU and LHU are zero-extended.
  - LW passes the word through.
  - wb_reg_we=ex_reg_we.
- Stores give wb_reg_we=0.
- Latency: minimum 2 cycles from acceptance to wb_valid (ack in the first request cycle). Each extra wait cycle adds 1.
- ex_ready=0 for the whole of BUS_WAIT. A new instruction can be accepted on the ack edge's following cycle.
- bus_ack while IDLE or while bus_req=0 is ignored.
- Writeback applies no backpressure. wb_* fields hold their values while wb_valid=0, but consumers must qualify with wb_valid.
- Undefined ex_mem_op codes are treated as MEM_NONE.

Decomposition:
- Shared package mips_mem_pkg holds:
  - mem_op codes: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8.
  - Exception codes EXC_ADEL=4 and EXC_ADES=5.
  - Helpers is_load and is_store.
- One combinational sub-module, load_align (rdata, addr[1:0], mem_op → 32-bit extended result). It is reused by any future uncached-load path.

Test Plan:
- ALU passthrough: op NONE, result 0x1234_5678, reg_we=1, waddr=3 → one cycle later wb_valid=1, wdata=0x1234_5678, waddr=3, no bus_req.
- LB sign-extend: addr 0x1000_0003, rdata 0x80AA_BBCC, ack after 2 wait cycles → bus_addr 0x1000_0000, be 4'b1111, wdata 0xFFFF_FF80, ex_ready low for 3 cycles.
- LHU zero-extend: addr 0x2002, rdata 0xBEEF_1234 → wdata 0x0000_BEEF. Same access as LH → 0xFFFF_BEEF.
- SB lane: addr 0x0000_0101, wdata 0x0000_00A5 → bus_be 4'b0010, bus_wdata 0xA5A5_A5A5, bus_we=1, wb_reg_we=0.
- Misaligned: LW at 0x0000_0006 → no bus_req, wb_exc=1, code 4, badvaddr 0x6. SH at 0x7 → code 5.
- Reset mid-transaction: rst pulsed while bus_req=1 and no ack → bus_req=0 and wb_valid=0 immediately (asynchronous). After release the stage is IDLE with ex_ready=1, and a late bus_ack is ignored.
